// File: rtl/pie_pkg.sv
// pie_pkg -- shared definitions for the PIE (pulse-interval encoding) encoder.
//   pie_state_t : encoder frame states
//   PIE_*_DEF   : default timing constants, in sample periods
//   pie_max3    : constant helper used to size the segment counter
package pie_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DELIM = 3'd1,
        ST_DATA0 = 3'd2,
        ST_RTCAL = 3'd3,
        ST_TRCAL = 3'd4,
        ST_DATA  = 3'd5
    } pie_state_t;

    localparam int PIE_PW_DEF    = 4;   // low-pulse width closing every symbol
    localparam int PIE_TARI_DEF  = 8;   // data-0 symbol length
    localparam int PIE_DATA1_DEF = 14;  // data-1 symbol length
    localparam int PIE_DELIM_DEF = 4;   // all-low delimiter length
    localparam int PIE_TRCAL_DEF = 40;  // TRcal symbol length

    function automatic int pie_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pie_seg_gen.sv
// pie_seg_gen -- one PIE segment: high for len-PW samples, then low for PW
// samples (or low for the whole segment when all_low is set).
//   clk, rst  : clock, synchronous active-high reset
//   clr       : restart the segment at sample 0 (new frame)
//   stb       : advance one sample
//   all_low   : segment is a delimiter (no high part)
//   len       : segment length in samples, held stable for the segment
//   level     : waveform level of the current sample
//   last      : current sample is the final one of the segment
module pie_seg_gen #(
    parameter int CW = 6,
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          stb,
    input  logic          all_low,
    input  logic [CW-1:0] len,
    output logic          level,
    output logic          last
);

    localparam logic [CW-1:0] PW_W = CW'(PW);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt;

    assign last  = (cnt == len - ONE);
    // The closing low pulse occupies the final PW samples of the segment.
    assign level = !all_low && (cnt < len - PW_W);

    // Counter self-wraps on the last sample so the next segment starts at 0
    // without any help from the controller.
    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (stb)
            cnt <= last ? '0 : cnt + ONE;
    end

endmodule

// File: rtl/pie_encoder.sv
// pie_encoder -- frames a bit stream as a PIE waveform:
//   delimiter, data-0, RTcal, optional TRcal, then one symbol per payload bit.
//   clk, rst     : clock, synchronous active-high reset
//   smp_stb      : one output sample is produced per strobe cycle
//   start        : frame request (ignored while busy)
//   preamble     : 1 = Query preamble (with TRcal), 0 = frame-sync; taken with start
//   in_bit/in_last/in_vld, in_rdy : payload handshake into a one-entry buffer
//   out_pie      : registered waveform, 1 = carrier on
//   busy         : frame in progress
//   done / err   : one-cycle pulses for normal end and for underrun
module pie_encoder
    import pie_pkg::*;
#(
    parameter int PW    = PIE_PW_DEF,
    parameter int TARI  = PIE_TARI_DEF,
    parameter int DATA1 = PIE_DATA1_DEF,
    parameter int DELIM = PIE_DELIM_DEF,
    parameter int TRCAL = PIE_TRCAL_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic smp_stb,
    input  logic start,
    input  logic preamble,
    input  logic in_bit,
    input  logic in_last,
    input  logic in_vld,
    output logic in_rdy,
    output logic out_pie,
    output logic busy,
    output logic done,
    output logic err
);

    localparam int RTCAL = TARI + DATA1;
    localparam int CW    = $clog2(pie_max3(DATA1, TRCAL, RTCAL) + 1);

    localparam logic [CW-1:0] L_DELIM = CW'(DELIM);
    localparam logic [CW-1:0] L_TARI  = CW'(TARI);
    localparam logic [CW-1:0] L_DATA1 = CW'(DATA1);
    localparam logic [CW-1:0] L_RTCAL = CW'(RTCAL);
    localparam logic [CW-1:0] L_TRCAL = CW'(TRCAL);

    // Timing ratios, in integer form: 1.5*TARI <= DATA1 <= 2*TARI and
    // 1.1*RTCAL <= TRCAL <= 3*RTCAL.
    generate
        if (!(PW < TARI) ||
            (2 * DATA1 < 3 * TARI) || (DATA1 > 2 * TARI) ||
            (10 * TRCAL < 11 * RTCAL) || (TRCAL > 3 * RTCAL)) begin : g_bad_timing
            $error("pie_encoder: illegal PIE timing parameters");
        end
    endgenerate

    pie_state_t    state, state_nxt;
    logic          preamble_q;
    logic          buf_full, buf_bit, last_acc, cur_bit;
    logic [CW-1:0] seg_len;
    logic          all_low, seg_level, seg_last;
    logic          start_acc, seg_stb, seg_end, xfer;
    logic          decide, pop, fin_done, fin_err;

    assign start_acc = (state == ST_IDLE) && start;
    assign seg_stb   = smp_stb && (state != ST_IDLE);
    assign seg_end   = seg_stb && seg_last;
    assign xfer      = in_vld && in_rdy;

    pie_seg_gen #(
        .CW (CW),
        .PW (PW)
    ) u_seg (
        .clk     (clk),
        .rst     (rst),
        .clr     (start_acc),
        .stb     (seg_stb),
        .all_low (all_low),
        .len     (seg_len),
        .level   (seg_level),
        .last    (seg_last)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // ---------------- next state ----------------
    // RTcal, TRcal and data symbols all end at a decision point: continue
    // with the buffered bit, finish cleanly, or flag an underrun.
    always_comb begin
        state_nxt = state;
        decide    = 1'b0;
        pop       = 1'b0;
        fin_done  = 1'b0;
        fin_err   = 1'b0;
        unique case (state)
            ST_IDLE:  if (start) state_nxt = ST_DELIM;
            ST_DELIM: if (seg_end) state_nxt = ST_DATA0;
            ST_DATA0: if (seg_end) state_nxt = ST_RTCAL;
            ST_RTCAL: begin
                if (seg_end) begin
                    if (preamble_q) state_nxt = ST_TRCAL;
                    else            decide    = 1'b1;
                end
            end
            ST_TRCAL: if (seg_end) decide = 1'b1;
            ST_DATA:  if (seg_end) decide = 1'b1;
            default:  state_nxt = ST_IDLE;
        endcase

        if (decide) begin
            if (buf_full) begin
                state_nxt = ST_DATA;
                pop       = 1'b1;
            end else if (last_acc) begin
                state_nxt = ST_IDLE;
                fin_done  = 1'b1;
            end else begin
                state_nxt = ST_IDLE;
                fin_err   = 1'b1;
            end
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        seg_len = L_TARI;
        all_low = 1'b0;
        unique case (state)
            ST_DELIM: begin seg_len = L_DELIM; all_low = 1'b1; end
            ST_DATA0: seg_len = L_TARI;
            ST_RTCAL: seg_len = L_RTCAL;
            ST_TRCAL: seg_len = L_TRCAL;
            ST_DATA:  seg_len = cur_bit ? L_DATA1 : L_TARI;
            default:  seg_len = L_TARI;
        endcase
        busy   = (state != ST_IDLE);
        in_rdy = busy && !buf_full && !last_acc;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_pie    <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            preamble_q <= 1'b0;
            buf_full   <= 1'b0;
            buf_bit    <= 1'b0;
            last_acc   <= 1'b0;
            cur_bit    <= 1'b0;
        end else begin
            done <= fin_done;
            err  <= fin_err;

            // The waveform only moves on strobes; idle (including the start
            // acceptance cycle) drives carrier-on.
            if (smp_stb)
                out_pie <= (state == ST_IDLE) ? 1'b1 : seg_level;

            if (start_acc)
                preamble_q <= preamble;

            if (pop)
                cur_bit <= buf_bit;

            // in_rdy requires an empty buffer and pop requires a full one, so
            // a transfer and a pop never collide; the pop reads the old entry.
            if (start_acc || fin_err) begin
                buf_full <= 1'b0;
                last_acc <= 1'b0;
            end else if (xfer) begin
                buf_full <= 1'b1;
                buf_bit  <= in_bit;
                if (in_last)
                    last_acc <= 1'b1;
            end else if (pop) begin
                buf_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pie_encoder.sv
module tb_pie_encoder;

    logic clk = 1'b0;
    logic rst, smp_stb, start, preamble, in_bit, in_last, in_vld;
    logic in_rdy, out_pie, busy, done, err;

    pie_encoder dut (
        .clk      (clk),
        .rst      (rst),
        .smp_stb  (smp_stb),
        .start    (start),
        .preamble (preamble),
        .in_bit   (in_bit),
        .in_last  (in_last),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .out_pie  (out_pie),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic b; logic l;} fb_t;

    int        n_chk = 0, n_err = 0;
    logic      exp_q[$];     // expected samples for the current frame
    logic      cap_q[$];     // captured samples for the current frame
    logic [1:0] ev_q[$];     // expected end event: 2'b10 done, 2'b01 err
    fb_t       feed_q[$];
    int        stb_div = 1;
    int        gap_max = 0;
    int        ev_cnt  = 0;
    bit        frame_on = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // strobe generator: every cycle, or one cycle in stb_div
    initial begin
        int ph;
        ph = 0;
        smp_stb = 1'b0;
        forever begin
            @(negedge clk);
            if (stb_div <= 1) smp_stb = 1'b1;
            else begin
                smp_stb = (ph == 0);
                ph = (ph + 1) % stb_div;
            end
        end
    end

    // payload feeder with random gaps
    initial begin
        bit hit;
        int gap;
        gap = 0;
        forever begin
            @(posedge clk);
            hit = in_vld && in_rdy && !rst;
            @(negedge clk);
            if (hit) begin
                if (feed_q.size() > 0) void'(feed_q.pop_front());
                in_vld = 1'b0;
                gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
            end
            if (!in_vld && feed_q.size() > 0) begin
                if (gap > 0) gap--;
                else begin
                    in_bit  = feed_q[0].b;
                    in_last = feed_q[0].l;
                    in_vld  = 1'b1;
                end
            end
        end
    end

    // monitor / scoreboard
    initial begin
        logic pa, ps, pr, e;
        logic [1:0] ee;
        forever begin
            @(posedge clk);
            pa = start && !busy && !rst;
            ps = smp_stb;
            pr = rst;
            #1;
            if (pr) frame_on = 0;
            else begin
                if (frame_on && ps) begin
                    cap_q.push_back(out_pie);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("out_pie sample", {31'd0, out_pie}, {31'd0, e});
                    end
                end
                if (done || err) begin
                    if (ev_q.size() == 0) check("unexpected end event", {30'd0, done, err}, 32'd0);
                    else begin
                        ee = ev_q.pop_front();
                        check("end event done/err", {30'd0, done, err}, {30'd0, ee});
                    end
                    frame_on = 0;
                    ev_cnt++;
                end
                if (pa) begin
                    frame_on = 1;
                    cap_q.delete();
                end
            end
        end
    end

    task automatic push_run(input logic lvl, input int n);
        repeat (n) exp_q.push_back(lvl);
    endtask

    task automatic push_sym(input int len);
        push_run(1'b1, len - 4);
        push_run(1'b0, 4);
    endtask

    task automatic build(input logic pre, input logic [7:0] bv, input int n);
        push_run(1'b0, 4);
        push_sym(8);
        push_sym(22);
        if (pre) push_sym(40);
        for (int i = 0; i < n; i++) push_sym(bv[i] ? 14 : 8);
    endtask

    task automatic feed(input logic [7:0] bv, input int n, input logic mark_last);
        for (int i = 0; i < n; i++) feed_q.push_back('{b: bv[i], l: mark_last && (i == n - 1)});
    endtask

    task automatic do_start(input logic pre);
        @(negedge clk);
        preamble = pre;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int c0;
        bit got;
        c0 = ev_cnt;
        got = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (ev_cnt != c0) begin got = 1; break; end
        end
        if (!got) check("frame end timeout", 32'd0, 32'd1);
    endtask

    task automatic check_idle(input string nm);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            if (smp_stb) break;
        end
        #1;
        check({nm, " out_pie idle"}, {31'd0, out_pie}, 32'd1);
        check({nm, " busy idle"}, {31'd0, busy}, 32'd0);
        check({nm, " in_rdy idle"}, {31'd0, in_rdy}, 32'd0);
    endtask

    // decode captured waveform back to bits from symbol lengths
    task automatic decode(output int nb, output logic [7:0] bo);
        int i, h, l, rt, idx;
        int lens[$];
        i = 0; nb = 0; bo = '0;
        while (i < cap_q.size() && cap_q[i] == 1'b0) i++;
        while (i < cap_q.size()) begin
            h = 0; l = 0;
            while (i < cap_q.size() && cap_q[i] == 1'b1) begin h++; i++; end
            while (i < cap_q.size() && cap_q[i] == 1'b0) begin l++; i++; end
            lens.push_back(h + l);
        end
        if (lens.size() >= 2) begin
            rt = lens[1];
            idx = 2;
            if (lens.size() > 2 && lens[2] > rt) idx = 3;
            for (int k = idx; k < lens.size() && nb < 8; k++) begin
                bo[nb] = (2 * lens[k] > rt);
                nb++;
            end
        end
    endtask

    initial begin
        int rl[13];
        int nb, n;
        logic [7:0] bo, bv;
        logic pre;
        bit okk;

        rst = 1'b1; start = 1'b0; preamble = 1'b0;
        in_bit = 1'b0; in_last = 1'b0; in_vld = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check("reset out_pie", {31'd0, out_pie}, 32'd1);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset in_rdy", {31'd0, in_rdy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset err", {31'd0, err}, 32'd0);
        // reset beats start in the same cycle
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst wins over start", {31'd0, busy}, 32'd0);

        // Query preamble, bits 1,0,1 -- hand-computed run table
        rl = '{4, 4, 4, 18, 4, 36, 4, 10, 4, 4, 4, 10, 4};
        for (int i = 0; i < 13; i++) push_run(i[0], rl[i]);
        feed(8'b101, 3, 1'b1);
        ev_q.push_back(2'b10);
        do_start(1'b1);
        wait_end(2000);
        check("t1 samples left", exp_q.size(), 32'd0);
        check("t1 sample count", cap_q.size(), 32'd110);
        check_idle("t1");

        // frame-sync, single bit 0
        build(1'b0, 8'b0, 1);
        feed(8'b0, 1, 1'b1);
        ev_q.push_back(2'b10);
        do_start(1'b0);
        wait_end(2000);
        check("t2 samples left", exp_q.size(), 32'd0);
        check("t2 sample count", cap_q.size(), 32'd42);
        check_idle("t2");

        // underrun after bit 2 of 4
        build(1'b0, 8'b01, 2);
        feed(8'b01, 2, 1'b0);
        ev_q.push_back(2'b01);
        do_start(1'b0);
        wait_end(2000);
        check("t3 samples left", exp_q.size(), 32'd0);
        check("t3 in_rdy after err", {31'd0, in_rdy}, 32'd0);
        check("t3 busy after err", {31'd0, busy}, 32'd0);
        check_idle("t3");

        // reset at strobe 30
        build(1'b1, 8'b1011, 4);
        feed(8'b1011, 4, 1'b1);
        ev_q.push_back(2'b10);
        do_start(1'b1);
        okk = 0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (cap_q.size() >= 29) begin okk = 1; break; end
        end
        if (!okk) check("t4 strobe wait timeout", 32'd0, 32'd1);
        rst = 1'b1;
        feed_q.delete(); in_vld = 1'b0;
        exp_q.delete(); ev_q.delete();
        @(negedge clk);
        rst = 1'b0;
        check("t4 samples before rst", cap_q.size(), 32'd29);
        check("t4 out_pie after rst", {31'd0, out_pie}, 32'd1);
        check("t4 busy after rst", {31'd0, busy}, 32'd0);
        check("t4 done/err after rst", {30'd0, done, err}, 32'd0);
        @(negedge clk);
        check("t4 no pulse after rst", {30'd0, done, err}, 32'd0);
        build(1'b1, 8'b101, 3);
        feed(8'b101, 3, 1'b1);
        ev_q.push_back(2'b10);
        do_start(1'b1);
        wait_end(2000);
        check("t4 new frame samples left", exp_q.size(), 32'd0);
        check("t4 new frame count", cap_q.size(), 32'd110);
        check_idle("t4");

        // sparse strobes, feed gaps, start while busy
        stb_div = 3; gap_max = 4;
        for (int i = 0; i < 13; i++) push_run(i[0], rl[i]);
        feed(8'b101, 3, 1'b1);
        ev_q.push_back(2'b10);
        do_start(1'b1);
        repeat (60) @(negedge clk);
        check("t5 busy mid-frame", {31'd0, busy}, 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_end(3000);
        check("t5 samples left", exp_q.size(), 32'd0);
        check("t5 sample count", cap_q.size(), 32'd110);
        check_idle("t5");

        // random loopback through a length-based decoder
        for (int f = 0; f < 200; f++) begin
            stb_div = $urandom_range(1, 2);
            gap_max = $urandom_range(0, 2);
            pre = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 6);
            bv = 8'($urandom_range(0, 255));
            build(pre, bv, n);
            feed(bv, n, 1'b1);
            ev_q.push_back(2'b10);
            do_start(pre);
            wait_end(3000);
            decode(nb, bo);
            check("loop bit count", nb, n);
            check("loop bits", {24'd0, bo & 8'((1 << n) - 1)}, {24'd0, bv & 8'((1 << n) - 1)});
            if (exp_q.size() != 0) begin
                check("loop samples left", exp_q.size(), 32'd0);
                exp_q.delete();
            end
        end
        stb_div = 1;
        check_idle("final");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pie_encoder.md
PIE_ENCODER -- requirements
Module: pie_encoder

Interface
REQ-001 SHALL have parameter PW, default 4: PIE low-pulse width, in samples.
REQ-002 SHALL have parameter TARI, default 8: data-0 symbol length, in samples.
REQ-003 SHALL have parameter DATA1, default 14: data-1 symbol length, in samples; RTCAL = TARI+DATA1 (22) is derived internally.
REQ-004 SHALL have parameter DELIM, default 4: delimiter length (all-low), in samples.
REQ-005 SHALL have parameter TRCAL, default 40: TRcal symbol length, in samples.
REQ-006 Port clk, input, 1: sole clock.
REQ-007 Port rst, input, 1: reset, synchronous to clk, active-high.
REQ-008 Port smp_stb, input, 1: sample strobe; one output sample per strobe cycle.
REQ-009 Port start, input, 1: frame request pulse.
REQ-010 Port preamble, input, 1: 1 selects Query preamble (with TRcal), 0 selects frame-sync; sampled with start.
REQ-011 Port in_bit / in_last / in_vld, input, 1 each: payload bit, final-bit flag, valid.
REQ-012 Port in_rdy, output, 1: bit buffer can accept.
REQ-013 Port out_pie, output, 1: registered PIE waveform, 1 = carrier on.
REQ-014 Port busy, output, 1: high from start acceptance until frame end.
REQ-015 Port done / err, output, 1 each: one-cycle pulses for normal end and underrun.

Function
REQ-016 States: IDLE, DELIM, DATA0, RTCAL, TRCAL, DATA; out_pie changes only on smp_stb cycles.
REQ-017 IDLE: out_pie=1, busy=0; start accepted in any cycle, start while busy ignored.
REQ-018 First DELIM sample is driven on the first smp_stb strictly after the start-acceptance cycle.
REQ-019 DELIM: out_pie=0 for DELIM strobes, then DATA0.
REQ-020 Segment of length L (DATA0, RTCAL, TRCAL, DATA symbol): out_pie=1 for L-PW strobes, then 0 for PW strobes.
REQ-021 Order: DELIM -> DATA0 -> RTCAL -> TRCAL (only if preamble=1) -> DATA per bit; bit 0 uses L=TARI, bit 1 uses L=DATA1.
REQ-022 One-entry bit buffer; in_rdy = busy && buffer empty && no in_last yet accepted; transfer on in_vld && in_rdy.
REQ-023 On the last strobe of RTCAL/TRCAL/DATA: buffer full -> pop, start DATA with the popped bit on the next strobe, no gap.
REQ-024 Same point, buffer empty and in_last already emitted -> done pulse next cycle, go IDLE, out_pie=1 on next strobe.
REQ-025 Same point, buffer empty and in_last not yet seen -> err pulse next cycle, go IDLE (underrun), buffer flushed.
REQ-026 Transfer and segment-end pop in the same cycle: the pop takes the existing entry, the new bit is stored; no loss.
REQ-027 Segment counter width = clog2(max(DATA1,TRCAL,RTCAL)+1); no wrap inside a segment.
REQ-028 Elaboration check: PW < TARI, 1.5*TARI <= DATA1 <= 2*TARI, 1.1*RTCAL <= TRCAL <= 3*RTCAL.

Reset
REQ-029 rst SHALL win over start, strobe and handshake in the same cycle.
REQ-030 rst SHALL set state=IDLE, out_pie=1, in_rdy=0, busy=0, done=0, err=0, buffer empty, counters 0.
REQ-031 rst mid-frame SHALL abort the frame; out_pie=1 in the cycle after rst, with no done or err pulse.

Structure
REQ-032 A shared package pie_pkg SHALL hold the state enum and the default timing constants.
REQ-033 A single sub-module pie_seg_gen SHALL take a segment length and a strobe and produce the high/low level and a last-sample flag.

Verification
REQ-034 Strobe every cycle, preamble=1, bits 1,0,1 (last on the third) -> 110 strobes: low 4; H4 L4; H18 L4; H36 L4; H10 L4; H4 L4; H10 L4; then done pulse, out_pie=1.
REQ-035 preamble=0, single bit 0 with last -> DELIM, DATA0, RTCAL, one 8-sample symbol; 42 strobes total; no TRcal.
REQ-036 in_vld withheld after bit 2 of 4 -> err pulse after bit 2's PW, in_rdy=0, state IDLE, out_pie=1.
REQ-037 rst asserted at strobe 30 of a frame -> out_pie=1 and busy=0 next cycle; a new start afterwards produces a correct frame.
REQ-038 smp_stb one-in-3 with random in_vld gaps that never underrun -> sample sequence identical to the strobe-every-cycle case; start during busy ignored.
REQ-039 Loopback through an FM0-independent PIE decoder model, 200 random frames -> all bits recovered, zero err pulses.
